upsample2x_nn: RTL and testbench

- 2x nearest-neighbour upsampling block; the inverse of the 2x2 maxpool stage.
- Takes a raster-order stream of IN_WIDTH x IN_HEIGHT pixels, 3 channels per beat.
- Emits a 2*IN_WIDTH x 2*IN_HEIGHT raster stream: each pixel is repeated horizontally, and each row is repeated vertically.
- Sits on the decoder/reconstruction path, between a feature-map producer and the next conv stage. Valid/ready handshake on both sides.

---
 rtl/upsample2x_nn_if.sv | 33 +++
 rtl/upsample2x_nn.sv | 162 ++++++++++++++++
 tb/tb_upsample2x_nn.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upsample2x_nn_if.sv
// ----------------------------------------------------------------------------
// upsample2x_nn_if : stream handshake bundle for the 2x NN upsampler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface upsample2x_nn_if #(
    parameter int DATA_BIT = 12
);
    logic                valid_in;
    logic                ready_in;
    logic [DATA_BIT-1:0] data_in_1;
    logic [DATA_BIT-1:0] data_in_2;
    logic [DATA_BIT-1:0] data_in_3;
    logic                valid_out;
    logic                ready_out;
    logic [DATA_BIT-1:0] data_out_1;
    logic [DATA_BIT-1:0] data_out_2;
    logic [DATA_BIT-1:0] data_out_3;
    logic                frame_done;

    modport slave (
        input  valid_in, data_in_1, data_in_2, data_in_3, ready_out,
        output ready_in, valid_out, data_out_1, data_out_2, data_out_3, frame_done
    );

    modport master (
        output valid_in, data_in_1, data_in_2, data_in_3, ready_out,
        input  ready_in, valid_out, data_out_1, data_out_2, data_out_3, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/upsample2x_nn.sv
// ----------------------------------------------------------------------------
// upsample2x_nn : 2x nearest-neighbour upsampler, row buffer replays each row
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module upsample2x_nn #(
    parameter int DATA_BIT      = 12,
    parameter int IN_WIDTH      = 12,
    parameter int IN_HEIGHT     = 12,
    parameter int IN_WIDTH_BIT  = 4,
    parameter int IN_HEIGHT_BIT = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    upsample2x_nn_if.slave      bus
);
    localparam int PIX_BIT   = 3 * DATA_BIT;
    localparam int BUF_DEPTH = 1 << IN_WIDTH_BIT;
    // Read column needs one extra bit to express "past the last column".
    localparam int RD_BIT    = IN_WIDTH_BIT + 1;
    localparam logic [IN_WIDTH_BIT-1:0]  LAST_COL = IN_WIDTH_BIT'(IN_WIDTH - 1);
    localparam logic [RD_BIT-1:0]        END_COL  = RD_BIT'(IN_WIDTH);
    localparam logic [IN_HEIGHT_BIT-1:0] LAST_ROW = IN_HEIGHT_BIT'(IN_HEIGHT - 1);

    typedef enum logic [0:0] {
        S_FILL   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [IN_WIDTH_BIT-1:0]  in_col_q, in_col_d;
    logic [RD_BIT-1:0]        rd_col_q, rd_col_d;
    logic [IN_HEIGHT_BIT-1:0] row_q, row_d;
    logic                     hcopy_q, hcopy_d;
    logic                     row_full_q, row_full_d;
    logic                     valid_out_q, valid_out_d;
    logic [PIX_BIT-1:0]       data_out_q, data_out_d;
    logic                     frame_done_q, frame_done_d;

    logic [PIX_BIT-1:0]       row_buf [BUF_DEPTH];

    logic                     w_ready_in;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_buf_we;
    logic [PIX_BIT-1:0]       w_pix_in;
    logic [PIX_BIT-1:0]       w_buf_rd;

    assign w_pix_in   = {bus.data_in_3, bus.data_in_2, bus.data_in_1};
    // rd_col stays 0 throughout FILL, so the same port yields buf[0] on entry to REPLAY.
    assign w_buf_rd   = row_buf[rd_col_q[IN_WIDTH_BIT-1:0]];
    assign w_ready_in = (state_q == S_FILL) && !row_full_q &&
                        (!valid_out_q || (bus.ready_out && hcopy_q));
    assign w_in_fire  = bus.valid_in && w_ready_in;
    assign w_out_fire = valid_out_q && bus.ready_out;

    always_comb begin
        state_d      = state_q;
        in_col_d     = in_col_q;
        rd_col_d     = rd_col_q;
        row_d        = row_q;
        hcopy_d      = hcopy_q;
        row_full_d   = row_full_q;
        valid_out_d  = valid_out_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        w_buf_we     = 1'b0;

        case (state_q)
            S_FILL: begin
                if (w_in_fire) begin
                    data_out_d  = w_pix_in;
                    w_buf_we    = 1'b1;
                    valid_out_d = 1'b1;
                    hcopy_d     = 1'b0;
                    if (in_col_q == LAST_COL) begin
                        in_col_d   = '0;
                        row_full_d = 1'b1;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end else if (w_out_fire) begin
                    if (!hcopy_q) begin
                        hcopy_d = 1'b1;
                    end else if (row_full_q) begin
                        state_d    = S_REPLAY;
                        data_out_d = w_buf_rd;
                        rd_col_d   = RD_BIT'(1);
                        hcopy_d    = 1'b0;
                    end else begin
                        valid_out_d = 1'b0;
                    end
                end
            end
            S_REPLAY: begin
                if (w_out_fire) begin
                    if (!hcopy_q) begin
                        hcopy_d = 1'b1;
                    end else if (rd_col_q != END_COL) begin
                        data_out_d = w_buf_rd;
                        rd_col_d   = rd_col_q + 1'b1;
                        hcopy_d    = 1'b0;
                    end else begin
                        valid_out_d = 1'b0;
                        state_d     = S_FILL;
                        row_full_d  = 1'b0;
                        rd_col_d    = '0;
                        if (row_q == LAST_ROW) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            in_col_q     <= '0;
            rd_col_q     <= '0;
            row_q        <= '0;
            hcopy_q      <= 1'b0;
            row_full_q   <= 1'b0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_col_q     <= in_col_d;
            rd_col_q     <= rd_col_d;
            row_q        <= row_d;
            hcopy_q      <= hcopy_d;
            row_full_q   <= row_full_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Row storage is intentionally left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_buf_we) begin
            row_buf[in_col_q] <= w_pix_in;
        end
    end

    assign bus.ready_in   = w_ready_in;
    assign bus.valid_out  = valid_out_q;
    assign bus.data_out_1 = data_out_q[DATA_BIT-1:0];
    assign bus.data_out_2 = data_out_q[2*DATA_BIT-1:DATA_BIT];
    assign bus.data_out_3 = data_out_q[3*DATA_BIT-1:2*DATA_BIT];
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_upsample2x_nn.sv
// ----------------------------------------------------------------------------
// tb_upsample2x_nn : directed self-checking bench for the 2x NN upsampler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_upsample2x_nn;
    localparam int DW = 12;
    localparam int W  = 4;
    localparam int H  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upsample2x_nn_if #(.DATA_BIT(DW)) bus ();

    upsample2x_nn #(
        .DATA_BIT(DW), .IN_WIDTH(W), .IN_HEIGHT(H),
        .IN_WIDTH_BIT(2), .IN_HEIGHT_BIT(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Observations gathered on the falling edge, between active edges.
    wire [3*DW-1:0] mon_data = {bus.data_out_3, bus.data_out_2, bus.data_out_1};
    logic [3*DW-1:0] out_q [$];
    int              out_cyc [$];
    int              out_in [$];
    int              fd_cyc [$];
    int              fd_beats [$];
    int              cyc       = 0;
    int              in_cnt    = 0;
    int              stall_err = 0;
    int              hs_err    = 0;
    logic            prev_stall = 1'b0;
    logic [3*DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.valid_out && bus.ready_out) begin
                out_q.push_back(mon_data);
                out_cyc.push_back(cyc);
                out_in.push_back(in_cnt + ((bus.valid_in && bus.ready_in) ? 1 : 0));
            end
            if (bus.valid_in && bus.ready_in) in_cnt <= in_cnt + 1;
            if (bus.frame_done) begin
                fd_cyc.push_back(cyc);
                fd_beats.push_back(out_q.size());
            end
            if (prev_stall && (!bus.valid_out || mon_data !== prev_data))
                stall_err <= stall_err + 1;
            if (bus.valid_in && bus.ready_in && bus.valid_out && !bus.ready_out)
                hs_err <= hs_err + 1;
            prev_stall <= bus.valid_out && !bus.ready_out;
            prev_data  <= mon_data;
        end
    end

    logic [3*DW-1:0] in_pix [$];
    logic [3*DW-1:0] exp_q [$];

    function automatic logic [3*DW-1:0] pix(input logic [DW-1:0] c1, input logic [DW-1:0] c2,
                                            input logic [DW-1:0] c3);
        return {c3, c2, c1};
    endfunction

    // Reference: each row emitted twice, each pixel twice within a row.
    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r < in_pix.size() / W; r++)
            for (int rep = 0; rep < 2; rep++)
                for (int c = 0; c < W; c++) begin
                    exp_q.push_back(in_pix[r*W + c]);
                    exp_q.push_back(in_pix[r*W + c]);
                end
    endtask

    task automatic run_stream(input bit gapped, input bit rand_rdy, input int base,
                              input int n_exp, output bit ok);
        bit done;
        done = 1'b0;
        ok   = 1'b1;
        fork
            begin
                foreach (in_pix[i]) begin
                    int  g;
                    int  guard;
                    bit  acc;
                    g = gapped ? ((i * 7 + 3) % 6) : 0;
                    bus.valid_in = 1'b0;
                    repeat (g) begin @(posedge clk); #1; end
                    bus.valid_in = 1'b1;
                    {bus.data_in_3, bus.data_in_2, bus.data_in_1} = in_pix[i];
                    acc   = 1'b0;
                    guard = 0;
                    while (!acc && guard < 200) begin
                        @(negedge clk);
                        acc = bus.ready_in;
                        @(posedge clk); #1;
                        guard++;
                    end
                end
                bus.valid_in = 1'b0;
            end
            begin
                while (!done) begin
                    bus.ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(posedge clk); #1;
                end
                bus.ready_out = 1'b1;
            end
            begin
                int t;
                t = 0;
                while (out_q.size() < base + n_exp && t < 2000) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (t >= 2000) ok = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                done = 1'b1;
            end
        join
    endtask

    task automatic test_reset();
        int b0;
        b0 = out_q.size();
        rst_n = 1'b0;
        bus.valid_in  = 1'b1;
        bus.ready_out = 1'b1;
        {bus.data_in_3, bus.data_in_2, bus.data_in_1} = pix(12'h123, 12'h456, 12'h789);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        checks++;
        if (mon_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", mon_data); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        #1;
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %b want 1", bus.ready_in); end
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_after: got %b want 0", bus.valid_out); end
        checks++;
        if (out_q.size() != b0) begin errors++; $display("FAIL reset_no_beat: got %0d beats want 0", out_q.size() - b0); end
        @(posedge clk); #1;
    endtask

    task automatic test_row_replay();
        int b0, i0;
        bit ok;
        in_pix.delete();
        for (int i = 1; i <= 8; i++) in_pix.push_back(pix(DW'(i), '0, '0));
        build_exp();
        b0 = out_q.size();
        i0 = in_cnt;
        run_stream(1'b0, 1'b0, b0, 32, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL row_timeout: got %0d beats want 32", out_q.size() - b0); end
        if (out_q.size() >= b0 + 17) begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (out_q[b0+k] !== exp_q[k]) begin
                    errors++; $display("FAIL row_beat%0d: got %0h want %0h", k, out_q[b0+k], exp_q[k]);
                end
            end
            checks++;
            if (out_cyc[b0+15] - out_cyc[b0] != 15) begin
                errors++; $display("FAIL row_no_gap: got %0d cycles want 15", out_cyc[b0+15] - out_cyc[b0]);
            end
            checks++;
            if (out_in[b0+15] - i0 != 4) begin
                errors++; $display("FAIL row_replay_no_input: got %0d inputs want 4", out_in[b0+15] - i0);
            end
            checks++;
            if (out_cyc[b0+16] - out_cyc[b0+15] != 2) begin
                errors++; $display("FAIL row_one_bubble: got %0d cycles want 2", out_cyc[b0+16] - out_cyc[b0+15]);
            end
        end
    endtask

    task automatic test_frame();
        int b0, f0;
        bit ok;
        in_pix.delete();
        for (int f = 0; f < 2; f++)
            for (int i = 1; i <= 8; i++) in_pix.push_back(pix(DW'(i), 12'hFFB, 12'h7FF));
        build_exp();
        b0 = out_q.size();
        f0 = fd_cyc.size();
        run_stream(1'b0, 1'b0, b0, 64, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_timeout: got %0d beats want 64", out_q.size() - b0); end
        checks++;
        if (fd_cyc.size() - f0 != 2) begin errors++; $display("FAIL frame_fd_count: got %0d want 2", fd_cyc.size() - f0); end
        if (ok) begin
            for (int k = 0; k < 64; k++) begin
                checks++;
                if (out_q[b0+k] !== exp_q[k]) begin
                    errors++; $display("FAIL frame_beat%0d: got %0h want %0h", k, out_q[b0+k], exp_q[k]);
                end
            end
        end
        if (ok && fd_cyc.size() - f0 == 2) begin
            checks++;
            if (fd_beats[f0] != b0 + 32 || fd_cyc[f0] != out_cyc[b0+31] + 1) begin
                errors++; $display("FAIL frame_fd1: got beats %0d cyc %0d want beats %0d cyc %0d",
                                   fd_beats[f0] - b0, fd_cyc[f0], 32, out_cyc[b0+31] + 1);
            end
            checks++;
            if (fd_beats[f0+1] != b0 + 64 || fd_cyc[f0+1] != out_cyc[b0+63] + 1) begin
                errors++; $display("FAIL frame_fd2: got beats %0d cyc %0d want beats %0d cyc %0d",
                                   fd_beats[f0+1] - b0, fd_cyc[f0+1], 64, out_cyc[b0+63] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int b0, f0, s0, h0;
        bit ok;
        in_pix.delete();
        for (int i = 1; i <= 8; i++) in_pix.push_back(pix(DW'(i), 12'hFFB, 12'h7FF));
        build_exp();
        b0 = out_q.size();
        f0 = fd_cyc.size();
        s0 = stall_err;
        h0 = hs_err;
        run_stream(1'b0, 1'b1, b0, 32, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d beats want 32", out_q.size() - b0); end
        if (ok) begin
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (out_q[b0+k] !== exp_q[k]) begin
                    errors++; $display("FAIL bp_beat%0d: got %0h want %0h", k, out_q[b0+k], exp_q[k]);
                end
            end
        end
        checks++;
        if (stall_err != s0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", stall_err - s0); end
        checks++;
        if (hs_err != h0) begin errors++; $display("FAIL bp_input_while_stalled: got %0d want 0", hs_err - h0); end
        checks++;
        if (fd_cyc.size() - f0 != 1) begin errors++; $display("FAIL bp_fd_count: got %0d want 1", fd_cyc.size() - f0); end
    endtask

    task automatic test_starved();
        int b0, f0;
        bit ok;
        in_pix.delete();
        for (int i = 1; i <= 8; i++) in_pix.push_back(pix(DW'(i + 100), DW'(i), 12'h800));
        build_exp();
        b0 = out_q.size();
        f0 = fd_cyc.size();
        run_stream(1'b1, 1'b0, b0, 32, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL starve_timeout: got %0d beats want 32", out_q.size() - b0); end
        if (ok) begin
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (out_q[b0+k] !== exp_q[k]) begin
                    errors++; $display("FAIL starve_beat%0d: got %0h want %0h", k, out_q[b0+k], exp_q[k]);
                end
            end
            checks++;
            if (out_cyc[b0+2] - out_cyc[b0+1] <= 1) begin
                errors++; $display("FAIL starve_drop: got %0d cycles want >1", out_cyc[b0+2] - out_cyc[b0+1]);
            end
            checks++;
            if (out_cyc[b0+15] - out_cyc[b0+8] != 7 || out_cyc[b0+31] - out_cyc[b0+24] != 7) begin
                errors++; $display("FAIL starve_replay_contig: got %0d and %0d want 7 and 7",
                                   out_cyc[b0+15] - out_cyc[b0+8], out_cyc[b0+31] - out_cyc[b0+24]);
            end
        end
        checks++;
        if (fd_cyc.size() - f0 != 1) begin errors++; $display("FAIL starve_fd_count: got %0d want 1", fd_cyc.size() - f0); end
    endtask

    task automatic test_reset_mid_row();
        int b0, b1;
        bit ok, ok2;
        in_pix.delete();
        in_pix.push_back(pix(12'd1, 12'd1, 12'd1));
        in_pix.push_back(pix(12'd2, 12'd2, 12'd2));
        b0 = out_q.size();
        run_stream(1'b0, 1'b0, b0, 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_pre_timeout: got %0d beats want 3", out_q.size() - b0); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_pix.delete();
        for (int i = 9; i <= 12; i++) in_pix.push_back(pix(DW'(i), DW'(i), DW'(i)));
        build_exp();
        b1 = out_q.size();
        run_stream(1'b0, 1'b0, b1, 16, ok2);
        checks++;
        if (!ok2) begin errors++; $display("FAIL mid_timeout: got %0d beats want 16", out_q.size() - b1); end
        if (ok2) begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (out_q[b1+k] !== exp_q[k]) begin
                    errors++; $display("FAIL mid_beat%0d: got %0h want %0h", k, out_q[b1+k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        bus.data_in_1 = '0;
        bus.data_in_2 = '0;
        bus.data_in_3 = '0;
        test_reset();
        test_row_replay();
        test_frame();
        test_backpressure();
        test_starved();
        test_reset_mid_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
